// File: rtl/rpmem_bus.sv
// SPI-master bridge: one 32-bit memory-style request becomes one framed SPI transaction
// (CMD, ADDR, optional MASK, optional hold-wait, DATA) to the RP2040 Keks slave.
module rpmem_bus #(
  parameter int CLK_DIV      = 2,
  parameter int CS_SETUP     = 8,
  parameter int CS_HOLD      = 2,
  parameter int ADDR_BITS    = 24,
  parameter int WAIT_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic        write,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        ss,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  input  logic        hold
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_WAIT, S_HOLDOFF, S_DONE} state_t;
  typedef enum logic [1:0] {P_CMD, P_ADDR, P_MASK, P_DATA} phase_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_MASKED = 8'h04;

  state_t      state;
  phase_t      phase;
  phase_t      next_phase;
  logic [7:0]  cmd;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        write_q;
  logic [31:0] shreg;
  logic [6:0]  bit_cnt;
  logic [7:0]  div_cnt;
  logic [15:0] dly_cnt;
  logic [15:0] wait_cnt;
  logic        hold_meta;
  logic        hold_s;

  // Each phase is left-aligned in the shift register so mosi is always its MSB.
  function automatic logic [31:0] phase_word(input phase_t p);
    case (p)
      P_CMD:   return {cmd, 24'h0};
      P_ADDR:  return addr_q << (32 - ADDR_BITS);
      P_MASK:  return {4'h0, wstrb_q, 24'h0};
      default: return write_q ? wdata_q : 32'h0;
    endcase
  endfunction

  function automatic logic [6:0] phase_len(input phase_t p);
    case (p)
      P_ADDR:  return 7'(ADDR_BITS);
      P_DATA:  return 7'd32;
      default: return 7'd8;
    endcase
  endfunction

  always_comb begin
    next_phase = P_DATA;
    case (phase)
      P_CMD:   next_phase = P_ADDR;
      P_ADDR:  next_phase = (cmd == CMD_MASKED) ? P_MASK : P_DATA;
      default: next_phase = P_DATA;
    endcase
  end

  // mosi comes straight off a flop, so it never glitches between sclk edges.
  assign mosi = shreg[31];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_meta <= 1'b1;
      hold_s    <= 1'b1;
    end else begin
      hold_meta <= hold;
      hold_s    <= hold_meta;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all frame state updates with <= so every branch below reads pre-edge values.
    if (!resetn) begin
      state    <= S_IDLE;
      phase    <= P_CMD;
      ss       <= 1'b1;
      sclk     <= 1'b0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      rdata    <= 32'h0;
      shreg    <= 32'h0;
      bit_cnt  <= 7'd0;
      div_cnt  <= 8'd0;
      dly_cnt  <= 16'd0;
      wait_cnt <= 16'd0;
      cmd      <= 8'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      wstrb_q  <= 4'h0;
      write_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && !ready) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wstrb_q <= wstrb;
            write_q <= write;
            busy    <= 1'b1;
            err     <= 1'b0;
            dly_cnt <= 16'd0;
            cmd     <= !write ? CMD_READ : ((wstrb == 4'hF) ? CMD_WRITE : CMD_MASKED);
            // An empty write never touches the bus, so chip select stays high.
            ss      <= write && (wstrb == 4'h0);
            state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (write_q && (wstrb_q == 4'h0)) begin
            state <= S_DONE;
          end else if (dly_cnt == 16'(CS_SETUP - 1)) begin
            state   <= S_SHIFT;
            phase   <= P_CMD;
            shreg   <= {cmd, 24'h0};
            bit_cnt <= 7'd8;
            div_cnt <= 8'd0;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (div_cnt != 8'(CLK_DIV - 1)) begin
            div_cnt <= div_cnt + 8'd1;
          end else begin
            div_cnt <= 8'd0;
            if (!sclk) begin
              sclk <= 1'b1;
              if (phase == P_DATA && !write_q) rdata <= {rdata[30:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt != 7'd1) begin
                shreg   <= {shreg[30:0], 1'b0};
                bit_cnt <= bit_cnt - 7'd1;
              end else if (phase == P_DATA) begin
                shreg   <= 32'h0;
                dly_cnt <= 16'd0;
                state   <= S_HOLDOFF;
              end else if (phase == P_ADDR && !write_q) begin
                shreg    <= 32'h0;
                wait_cnt <= 16'd0;
                state    <= S_WAIT;
              end else begin
                phase   <= next_phase;
                shreg   <= phase_word(next_phase);
                bit_cnt <= phase_len(next_phase);
              end
            end
          end
        end
        S_WAIT: begin
          if (!hold_s) begin
            state   <= S_SHIFT;
            phase   <= P_DATA;
            shreg   <= phase_word(P_DATA);
            bit_cnt <= 7'd32;
            div_cnt <= 8'd0;
          end else if (WAIT_TIMEOUT != 0 && wait_cnt == 16'(WAIT_TIMEOUT - 1)) begin
            err     <= 1'b1;
            rdata   <= 32'hFFFF_FFFF;
            dly_cnt <= 16'd0;
            state   <= S_HOLDOFF;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_HOLDOFF: begin
          if (dly_cnt == 16'(CS_HOLD - 1)) begin
            ss    <= 1'b1;
            state <= S_DONE;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end
        S_DONE: begin
          if (!ready) begin
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (!valid) begin
            ready <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rpmem_bus.sv
// Bench for rpmem_bus: directed test-plan steps plus random requests, checked against
// a frame/latency model built from the bridge's protocol rules and a behavioural SPI slave.
module tb_rpmem_bus;

  localparam int CLK_DIV     = 2;
  localparam int CS_SETUP    = 4;
  localparam int CS_HOLD     = 2;
  localparam int ADDR_BITS   = 24;
  localparam int TO_WT       = 20;
  localparam int B           = 2 * CLK_DIV;
  localparam int HDR         = 8 + ADDR_BITS;
  localparam int FIRST_CHECK = 1 + CS_SETUP + HDR * B;
  localparam int BUDGET      = 2000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        miso = 1'b0;
  logic        hold = 1'b0;

  logic        ready, err, busy, ss, sclk, mosi;
  logic [31:0] rdata;
  logic        to_ready, to_err, to_busy, to_ss, to_sclk, to_mosi;
  logic [31:0] to_rdata;

  int checks = 0;
  int errors = 0;

  // Slave model state.
  logic        is_read = 1'b0;
  logic [31:0] resp = 32'h0;
  logic [79:0] cap = '0;
  int          rises = 0;
  int          frames = 0;
  logic        prev_ss = 1'b1;
  logic        prev_sclk = 1'b0;
  int          to_rises = 0;
  logic        to_prev_ss = 1'b1;
  logic        to_prev_sclk = 1'b0;

  always #5 clk = ~clk;

  rpmem_bus #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
              .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(ready), .write(write),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(rdata), .err(err), .busy(busy),
    .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso), .hold(hold)
  );

  rpmem_bus #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
              .ADDR_BITS(ADDR_BITS), .WAIT_TIMEOUT(TO_WT)) dut_to (
    .clk(clk), .resetn(resetn), .valid(valid), .ready(to_ready), .write(write),
    .wstrb(wstrb), .addr(addr), .wdata(wdata), .rdata(to_rdata), .err(to_err),
    .busy(to_busy), .ss(to_ss), .sclk(to_sclk), .mosi(to_mosi), .miso(miso), .hold(hold)
  );

  // Mode-0 slave: captures mosi on sclk rise, presents read data after each fall.
  always @(ss or sclk) begin
    if (prev_ss && !ss) begin
      rises = 0;
      cap = '0;
      frames++;
    end
    if (!ss && sclk && !prev_sclk) begin
      cap = {cap[78:0], mosi};
      rises++;
    end
    if (!ss && !sclk)
      miso = (is_read && rises >= HDR && rises < HDR + 32) ? resp[HDR + 31 - rises] : 1'b0;
    prev_ss = ss;
    prev_sclk = sclk;
  end

  always @(to_ss or to_sclk) begin
    if (to_prev_ss && !to_ss) to_rises = 0;
    if (!to_ss && to_sclk && !to_prev_sclk) to_rises++;
    to_prev_ss = to_ss;
    to_prev_sclk = to_sclk;
  end

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request through the main instance; w_high = synchronised hold-high checks on reads.
  task automatic do_txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input logic [31:0] rsp, input int w_high,
                        input int linger, input string tag);
    logic [7:0]  c;
    logic [79:0] f;
    logic        empty;
    int          nbits, exp_lat, n, frames0;
    c = !wr ? 8'h03 : ((ws == 4'hF) ? 8'h02 : 8'h04);
    empty = wr && (ws == 4'h0);
    nbits = HDR + 32 + ((c == 8'h04) ? 8 : 0);
    exp_lat = empty ? 2 : 1 + CS_SETUP + nbits * B + CS_HOLD + (wr ? 0 : 1 + w_high);
    f = 80'(c);
    f = (f << ADDR_BITS) | 80'(a[ADDR_BITS-1:0]);
    if (c == 8'h04) f = (f << 8) | 80'(ws);
    if (wr) f = (f << 32) | 80'(wd);
    is_read = !wr;
    resp = rsp;
    hold = !wr && (w_high > 0);
    frames0 = frames;
    write = wr; addr = a; wdata = wd; wstrb = ws; valid = 1'b1;
    n = 0;
    while (!ready && n < BUDGET) begin
      @(negedge clk);
      n++;
      // hold reaches the wait check three edges after it is driven (two sync flops + sample).
      if (n == FIRST_CHECK - 2 + w_high) hold = 1'b0;
    end
    check({tag, "_latency"}, 80'(n - 1), 80'(exp_lat));
    check({tag, "_busy"}, 80'(busy), 80'(0));
    check({tag, "_ss"}, 80'(ss), 80'(1));
    if (empty) begin
      check({tag, "_no_frame"}, 80'(frames), 80'(frames0));
    end else begin
      check({tag, "_frames"}, 80'(frames), 80'(frames0 + 1));
      check({tag, "_sclk_rises"}, 80'(rises), 80'(nbits));
      if (wr) begin
        check({tag, "_mosi"}, cap, f);
      end else begin
        check({tag, "_mosi_hdr"}, cap >> 32, f);
        check({tag, "_rdata"}, 80'(rdata), 80'(rsp));
        check({tag, "_err"}, 80'(err), 80'(0));
      end
    end
    for (int i = 0; i < linger; i++) begin
      @(negedge clk);
      check({tag, "_ready_held"}, 80'(ready), 80'(1));
    end
    if (linger > 0) check({tag, "_no_refire"}, 80'(frames), 80'(empty ? frames0 : frames0 + 1));
    valid = 1'b0;
    @(negedge clk);
    check({tag, "_ready_drop"}, 80'(ready), 80'(0));
    check({tag, "_ss_gap"}, 80'(ss), 80'(1));
    is_read = 1'b0;
  endtask

  initial begin
    int n;
    logic [31:0] r;
    logic        wr;
    logic [3:0]  ws;

    repeat (3) @(negedge clk);
    check("rst_ss", 80'(ss), 80'(1));
    check("rst_sclk", 80'(sclk), 80'(0));
    check("rst_mosi", 80'(mosi), 80'(0));
    check("rst_ready", 80'(ready), 80'(0));
    check("rst_busy", 80'(busy), 80'(0));
    check("rst_err", 80'(err), 80'(0));
    check("rst_rdata", 80'(rdata), 80'(0));
    resetn = 1'b1;
    @(negedge clk);

    do_txn(1'b1, 32'h0012_3456, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, "full_write");
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hCAFE_F00D, 0, 0, "read_hold_low");
    do_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1357_9BDF, 50, 0, "read_hold_50");

    // Timed-out read on the short-timeout instance; the main instance then finishes once hold drops.
    r = $urandom;
    is_read = 1'b1; resp = r; hold = 1'b1;
    write = 1'b0; addr = 32'h0000_0040; wstrb = 4'h0; valid = 1'b1;
    n = 0;
    while (!to_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", 80'(n - 1), 80'(1 + CS_SETUP + HDR * B + TO_WT + CS_HOLD));
    check("timeout_err", 80'(to_err), 80'(1));
    check("timeout_rdata", 80'(to_rdata), 80'(32'hFFFF_FFFF));
    check("timeout_rises", 80'(to_rises), 80'(HDR));
    check("timeout_ss", 80'(to_ss), 80'(1));
    check("timeout_sclk", 80'(to_sclk), 80'(0));
    hold = 1'b0;
    n = 0;
    while (!ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("timeout_main_rdata", 80'(rdata), 80'(r));
    valid = 1'b0;
    is_read = 1'b0;
    @(negedge clk);

    do_txn(1'b1, 32'h00AA_AAAA, 32'hDDDD_DDDD, 4'b0101, 32'h0, 0, 0, "masked_write");
    check("err_cleared_on_accept", 80'(to_err), 80'(0));
    do_txn(1'b1, 32'h0000_1234, 32'h5555_AAAA, 4'h0, 32'h0, 0, 0, "empty_write");

    // Reset in the middle of the address phase.
    write = 1'b1; addr = 32'h0065_4321; wdata = 32'h0BAD_F00D; wstrb = 4'hF; valid = 1'b1;
    repeat (60) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_ss", 80'(ss), 80'(1));
    check("midrst_sclk", 80'(sclk), 80'(0));
    check("midrst_ready", 80'(ready), 80'(0));
    check("midrst_busy", 80'(busy), 80'(0));
    check("midrst_mosi", 80'(mosi), 80'(0));
    valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    do_txn(1'b1, 32'h0065_4321, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 0, "after_reset");

    do_txn(1'b1, 32'h0001_0203, 32'h0405_0607, 4'hF, 32'h0, 0, 10, "handshake");
    do_txn(1'b0, 32'h0000_0080, 32'h0, 4'h0, 32'h8765_4321, 0, 0, "handshake_next");

    for (int i = 0; i < 12; i++) begin
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ws = 4'h0;
        1:       ws = 4'hF;
        default: ws = 4'($urandom);
      endcase
      do_txn(wr, $urandom, $urandom, ws, $urandom, wr ? 0 : int'($urandom_range(0, 15)),
             0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rpmem_bus.md
# rpmem_bus

Parametrised SPI-master bridge: turns single 32-bit memory-style requests from the SoC bus into framed SPI transactions to the RP2040 running the Keks slave firmware. It adds the following over the first-generation bridge:
- programmable SCK rate, CS setup and hold;
- configurable address width;
- byte-masked writes;
- a bounded wait on the slave `hold` line, with an error flag.

It sits between the CPU memory bus and the board-level SPI pins.

## Interface
- `CLK_DIV`, 2: SCK half-period in `clk` cycles; legal range 1..255.
- `CS_SETUP`, 8: `clk` cycles from `ss` falling to the first SCK edge; legal range 1..65535.
- `CS_HOLD`, 2: `clk` cycles from the last SCK falling edge to `ss` rising; legal range 1..255.
- `ADDR_BITS`, 24: address bits sent, taken from `addr[ADDR_BITS-1:0]`; must be 8, 16, 24 or 32.
- `WAIT_TIMEOUT`, 65535: maximum `clk` cycles to wait for `hold` low on reads; 0 means wait forever.

- `clk` in 1: single system clock.
- `resetn` in 1: synchronous, active-low reset.
- `valid` in 1: request strobe; held high until `ready`.
- `ready` out 1: completion; held high until `valid` drops.
- `write` in 1: 1 = write, 0 = read.
- `wstrb` in 4: byte enables for writes; ignored on reads.
- `addr` in 32: request address.
- `wdata` in 32: write data.
- `rdata` out 32: read data; valid while `ready` is high.
- `err` out 1: read timed out; valid while `ready` is high.
- `busy` out 1: high from request accept until `ready` rises.
- `ss` out 1: SPI chip select, active low.
- `sclk` out 1: SPI clock, mode 0.
- `mosi` out 1: SPI data out.
- `miso` in 1: SPI data in.
- `hold` in 1: slave not ready; synchronised internally with 2 flops.

## Operation
**Reset values:** `ss`=1, `sclk`=0, `mosi`=0, `ready`=0, `busy`=0, `err`=0, `rdata`=0. A reset mid-transfer forces these values on the next edge and aborts the frame without completing it.

**States:** IDLE → SETUP → SHIFT(CMD, ADDR, [MASK]) → [WAIT] → SHIFT(DATA) → HOLDOFF → DONE → IDLE.
- **IDLE:**
  - Accept a request when `valid`=1 and `ready`=0.
  - Latch `addr`, `wdata`, `wstrb` and `write`; set `busy`.
  - Choose the command byte: read = 0x03; write with `wstrb`=4'hF = 0x02; write with any other nonzero `wstrb` = 0x04.
- **Write with `wstrb`=0:** no SPI activity. Go straight to DONE with `err`=0.
- **SETUP:** drive `ss`=0 and count `CS_SETUP` cycles.
- **SHIFT:**
  - MSB first.
  - `mosi` is updated in the cycle `sclk` falls, or on entry to a phase, and is stable a full half-period before the rising edge.
  - `miso` is sampled on the `clk` edge that raises `sclk`.
  - Each bit takes 2×`CLK_DIV` cycles; `sclk` is low on exit.
  - CMD is 8 bits. ADDR is `ADDR_BITS` bits. MASK (command 0x04 only) is 8 bits, {4'b0, `wstrb`}. DATA is 32 bits: `wdata` on writes, captured into `rdata` on reads.
  - Phases are back-to-back with no gap cycles.
- **WAIT:** reads only, after ADDR.
  - Sample the synchronised `hold` once per cycle, with the first check in the cycle after the last address bit.
  - Leave when `hold`=0.
  - If `WAIT_TIMEOUT`≠0 and the wait counter reaches `WAIT_TIMEOUT`: set `err`=1, set `rdata`=32'hFFFFFFFF, skip DATA and go to HOLDOFF.
- **HOLDOFF:** keep `sclk`=0 and `ss`=0 for `CS_HOLD` cycles.
- **DONE:**
  - Drive `ss`=1, `ready`=1 and `busy`=0.
  - Stay until `valid`=0. Then `ready`=0 next cycle and return to IDLE.
  - `err` clears on the next accept.
- **Back-to-back requests:** `valid` held high after `ready` is not a new request. A new request needs `valid` to fall first, which gives `ss` at least 1 high cycle between frames.

## Timing
- Define N = 8 + `ADDR_BITS` + 32, plus 8 for command 0x04. Define B = 2×`CLK_DIV`.
- **Writes:** `ready` rises exactly 1 + `CS_SETUP` + N×B + `CS_HOLD` cycles after the accept edge.
- **Reads:** the same, +1 WAIT cycle, +W extra cycles where W is the number of cycles the synchronised `hold` stayed high.
- **Timed-out read:** `ready` rises 1 + `CS_SETUP` + (8+`ADDR_BITS`)×B + `WAIT_TIMEOUT` + `CS_HOLD` cycles after accept.
- **`wstrb`=0 write:** `ready` rises 2 cycles after accept.
- **Clock timing:** `sclk` high time and low time are each exactly `CLK_DIV` cycles, so there are no glitches or short pulses.
- **Widths:**
  - The bit counter must be at least 7 bits wide (N ≤ 80).
  - The wait counter is 16 bits and saturates.
  - The delay counter is 16 bits.

## Test plan
Bench parameters: `CLK_DIV`=2, `CS_SETUP`=4, `CS_HOLD`=2, `ADDR_BITS`=24.

- **Full write:** `addr`=0x123456, `wdata`=0xDEADBEEF, `wstrb`=F → MOSI bytes 02 12 34 56 DE AD BE EF; `ready` rises at cycle 263; exactly 64 `sclk` rising edges.
- **Read, hold low:** read `addr`=0x000010 with the slave model returning 0xCAFEF00D and `hold`=0 → MOSI bytes 03 00 00 10; `rdata`=0xCAFEF00D; `err`=0; `ready` at cycle 264.
- **Read, hold high for 50 cycles:** → `ready` at cycle 314, data correct. Repeat with `WAIT_TIMEOUT`=20 and `hold` stuck high → `err`=1, `rdata`=FFFFFFFF, 32 `sclk` edges only, `ss` released.
- **Masked and empty writes:** `wstrb`=4'b0101 → MOSI bytes 04 aa aa aa 05 dd dd dd dd. `wstrb`=0 → `ss` never falls, `ready` at cycle 2.
- **Reset mid-frame:** assert `resetn`=0 during the ADDR phase → `ss`=1, `sclk`=0, `ready`=0 next edge. The next request after reset completes normally.
- **Handshake:** hold `valid` high for 10 cycles after `ready` → `ready` stays high, no second frame; drop `valid` → `ready`=0 next cycle, with `ss` high at least 1 cycle before the next frame.
